sga_game_ctrl: RTL and testbench

Parametrised control unit for the Snake Game Arcade, the successor to the fixed single-life controller. It owns the game state machine, a snake-size counter, a lives counter, a play-tick timer and the segment render index. It sits between the input/sync logic (start, pause) and the datapath (position comparators, segment memory, apple generator), and drives the datapath with one-cycle Moore strobes.

---
 rtl/sga_pkg.sv | 37 +++
 rtl/sga_tick_timer.sv | 33 +++
 rtl/sga_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_sga_game_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sga_pkg.sv
// rtl/sga_pkg.sv - state encodings and default parameters for the snake game controller
package sga_pkg;

  typedef enum logic [4:0] {
    ST_IDLE              = 5'h00,
    ST_PREPARA           = 5'h01,
    ST_GERA_MACA_INICIAL = 5'h02,
    ST_RENDERIZA         = 5'h03,
    ST_ESPERA            = 5'h04,
    ST_REGISTRA          = 5'h05,
    ST_MOVE              = 5'h06,
    ST_COMPARA           = 5'h07,
    ST_COMEU_MACA        = 5'h08,
    ST_CRESCE            = 5'h09,
    ST_GERA_MACA         = 5'h0A,
    ST_PAUSOU            = 5'h0B,
    ST_FEZ_NADA          = 5'h0C,
    ST_PERDEU            = 5'h0D,
    ST_GANHOU            = 5'h0E,
    ST_PROXIMO_RENDER    = 5'h0F,
    ST_ATUALIZA_MEMORIA  = 5'h10,
    ST_MORREU            = 5'h11
  } state_t;

  localparam int DEF_SIZE_W      = 6;
  localparam int DEF_INIT_SIZE   = 3;
  localparam int DEF_MAX_SIZE    = 32;
  localparam int DEF_LIVES       = 3;
  localparam int DEF_TICK_CYCLES = 1000;
  localparam int DEF_TICK_W      = 10;

  // States that belong to the segment render pass; render_idx survives only here.
  function automatic logic in_render(input state_t s);
    return (s == ST_RENDERIZA) || (s == ST_ATUALIZA_MEMORIA) || (s == ST_PROXIMO_RENDER);
  endfunction

endpackage

// File: rtl/sga_tick_timer.sv
// rtl/sga_tick_timer.sv - play-tick counter with count/hold/clear control
module sga_tick_timer
  import sga_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int TICK_W      = DEF_TICK_W
) (
  input  logic clock,
  input  logic restart,
  input  logic count,
  input  logic hold,
  input  logic clear,
  output logic expire
);

  logic [TICK_W-1:0] cnt;

  // Clear wins over count; hold keeps the value frozen across a pause.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TICK_W'(1);
    end else if (hold) begin
      cnt <= cnt;
    end
  end

  assign expire = (cnt == TICK_W'(TICK_CYCLES - 1));

endmodule

// File: rtl/sga_game_ctrl.sv
// rtl/sga_game_ctrl.sv - snake game control FSM with size, lives, tick and render counters
module sga_game_ctrl
  import sga_pkg::*;
#(
  parameter int SIZE_W      = DEF_SIZE_W,
  parameter int INIT_SIZE   = DEF_INIT_SIZE,
  parameter int MAX_SIZE    = DEF_MAX_SIZE,
  parameter int LIVES       = DEF_LIVES,
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int TICK_W      = DEF_TICK_W
) (
  input  logic              clock,
  input  logic              restart,
  input  logic              start,
  input  logic              pause,
  input  logic              is_at_apple,
  input  logic              is_at_border,
  input  logic              is_at_body,
  output logic [SIZE_W-1:0] size,
  output logic [2:0]        lives_left,
  output logic [SIZE_W-1:0] render_idx,
  output logic              render_we,
  output logic              register_apple,
  output logic              reset_apple,
  output logic              move,
  output logic              register_dir,
  output logic              finished,
  output logic              won,
  output logic              lost,
  output logic [4:0]        db_state
);

  localparam logic [SIZE_W-1:0] INIT_S = SIZE_W'(INIT_SIZE);
  localparam logic [SIZE_W-1:0] MAX_S  = SIZE_W'(MAX_SIZE);
  localparam logic [2:0]        LIVES_L = 3'(LIVES);

  state_t state;
  state_t next_state;
  logic   tick_expire;
  logic   tick_count;
  logic   tick_hold;
  logic   tick_clear;

  // Tick runs only in an unpaused ESPERA; a pause request freezes it on the same edge.
  always_comb begin
    tick_count = 1'b0;
    tick_hold  = 1'b0;
    tick_clear = 1'b0;
    if (state == ST_ESPERA) begin
      if (pause)            tick_hold  = 1'b1;
      else if (tick_expire) tick_clear = 1'b1;
      else                  tick_count = 1'b1;
    end else if (state == ST_PAUSOU) begin
      tick_hold = 1'b1;
    end else begin
      tick_clear = 1'b1;
    end
  end

  sga_tick_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .TICK_W      (TICK_W)
  ) u_tick (
    .clock   (clock),
    .restart (restart),
    .count   (tick_count),
    .hold    (tick_hold),
    .clear   (tick_clear),
    .expire  (tick_expire)
  );

  // Next-state selection; collisions take priority over eating an apple.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:              if (start) next_state = ST_PREPARA;
      ST_PREPARA:           next_state = ST_GERA_MACA_INICIAL;
      ST_GERA_MACA_INICIAL: next_state = ST_RENDERIZA;
      ST_RENDERIZA:         next_state = ST_ATUALIZA_MEMORIA;
      ST_ATUALIZA_MEMORIA:  next_state = ST_PROXIMO_RENDER;
      ST_PROXIMO_RENDER:    next_state = (render_idx == size - SIZE_W'(1)) ? ST_ESPERA : ST_RENDERIZA;
      ST_ESPERA: begin
        if (pause)            next_state = ST_PAUSOU;
        else if (tick_expire) next_state = ST_REGISTRA;
      end
      ST_PAUSOU:            if (start) next_state = ST_ESPERA;
      ST_REGISTRA:          next_state = ST_MOVE;
      ST_MOVE:              next_state = ST_COMPARA;
      ST_COMPARA: begin
        if (is_at_border || is_at_body)
          next_state = (lives_left == 3'd1) ? ST_PERDEU : ST_MORREU;
        else if (is_at_apple)
          next_state = ST_COMEU_MACA;
        else
          next_state = ST_FEZ_NADA;
      end
      ST_MORREU:            next_state = ST_PREPARA;
      ST_COMEU_MACA:        next_state = ST_CRESCE;
      ST_CRESCE:            next_state = (size == MAX_S) ? ST_GANHOU : ST_GERA_MACA;
      ST_GERA_MACA:         next_state = ST_RENDERIZA;
      ST_FEZ_NADA:          next_state = ST_RENDERIZA;
      ST_GANHOU, ST_PERDEU: if (start) next_state = ST_PREPARA;
      default:              next_state = ST_IDLE;
    endcase
  end

  // State, counters and strobes; strobes decode the next state so they are glitch-free registers.
  always_ff @(posedge clock or posedge restart) begin
    if (restart) begin
      state          <= ST_IDLE;
      size           <= INIT_S;
      lives_left     <= LIVES_L;
      render_idx     <= '0;
      render_we      <= 1'b0;
      register_apple <= 1'b0;
      reset_apple    <= 1'b0;
      move           <= 1'b0;
      register_dir   <= 1'b0;
      finished       <= 1'b0;
      won            <= 1'b0;
      lost           <= 1'b0;
    end else begin
      state <= next_state;

      if (state == ST_IDLE || state == ST_PREPARA || next_state == ST_PREPARA)
        size <= INIT_S;
      else if (state == ST_COMEU_MACA && size < MAX_S)
        size <= size + SIZE_W'(1);

      if (state == ST_IDLE)
        lives_left <= LIVES_L;
      else if (state == ST_MORREU)
        lives_left <= lives_left - 3'd1;
      else if ((state == ST_GANHOU || state == ST_PERDEU) && next_state == ST_PREPARA)
        lives_left <= LIVES_L;

      if (!in_render(next_state))
        render_idx <= '0;
      else if (state == ST_PROXIMO_RENDER && next_state == ST_RENDERIZA)
        render_idx <= render_idx + SIZE_W'(1);

      render_we      <= (next_state == ST_ATUALIZA_MEMORIA);
      register_apple <= (next_state == ST_GERA_MACA_INICIAL) || (next_state == ST_GERA_MACA);
      reset_apple    <= (next_state == ST_COMEU_MACA);
      move           <= (next_state == ST_MOVE);
      register_dir   <= (next_state == ST_REGISTRA);
      finished       <= (next_state == ST_GANHOU) || (next_state == ST_PERDEU);
      won            <= (next_state == ST_GANHOU);
      lost           <= (next_state == ST_PERDEU);
    end
  end

  assign db_state = state;

endmodule

// File: tb/tb_sga_game_ctrl.sv
// tb/tb_sga_game_ctrl.sv - scoreboard bench for sga_game_ctrl
module tb_sga_game_ctrl;

  localparam int SIZE_W = 6, INIT_SIZE = 3, MAX_SIZE = 5, LIVES = 2, TICK_CYCLES = 4, TICK_W = 4;

  localparam logic [4:0] S_IDLE = 5'h00, S_PREPARA = 5'h01, S_GERA_INI = 5'h02, S_RENDERIZA = 5'h03;
  localparam logic [4:0] S_ESPERA = 5'h04, S_REGISTRA = 5'h05, S_MOVE = 5'h06, S_COMPARA = 5'h07;
  localparam logic [4:0] S_COMEU = 5'h08, S_CRESCE = 5'h09, S_GERA_MACA = 5'h0A, S_PAUSOU = 5'h0B;
  localparam logic [4:0] S_FEZ_NADA = 5'h0C, S_PERDEU = 5'h0D, S_GANHOU = 5'h0E, S_PROXIMO = 5'h0F;
  localparam logic [4:0] S_ATUALIZA = 5'h10, S_MORREU = 5'h11;

  logic              clock = 1'b0;
  logic              restart, start, pause, is_at_apple, is_at_border, is_at_body;
  logic [SIZE_W-1:0] size, render_idx;
  logic [2:0]        lives_left;
  logic              render_we, register_apple, reset_apple, move, register_dir;
  logic              finished, won, lost;
  logic [4:0]        db_state;
  logic [27:0]       obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [27:0] exp;
    logic st, ps, ap, bo, bd;
  } item_t;

  item_t sb[$];
  item_t it;

  sga_game_ctrl #(
    .SIZE_W(SIZE_W), .INIT_SIZE(INIT_SIZE), .MAX_SIZE(MAX_SIZE),
    .LIVES(LIVES), .TICK_CYCLES(TICK_CYCLES), .TICK_W(TICK_W)
  ) dut (
    .clock(clock), .restart(restart), .start(start), .pause(pause),
    .is_at_apple(is_at_apple), .is_at_border(is_at_border), .is_at_body(is_at_body),
    .size(size), .lives_left(lives_left), .render_idx(render_idx),
    .render_we(render_we), .register_apple(register_apple), .reset_apple(reset_apple),
    .move(move), .register_dir(register_dir), .finished(finished), .won(won),
    .lost(lost), .db_state(db_state)
  );

  always #5 clock = ~clock;

  assign obs = {db_state, size, lives_left, render_idx, render_we, register_apple,
                reset_apple, move, register_dir, finished, won, lost};

  // Expected observable word: strobes follow from the state by the Moore output table.
  function automatic logic [27:0] ew(input logic [4:0] s, input int sz, input int lv, input int idx);
    logic [7:0] stb;
    stb = {s == S_ATUALIZA, (s == S_GERA_INI) || (s == S_GERA_MACA), s == S_COMEU, s == S_MOVE,
           s == S_REGISTRA, (s == S_GANHOU) || (s == S_PERDEU), s == S_GANHOU, s == S_PERDEU};
    return {s, 6'(sz), 3'(lv), 6'(idx), stb};
  endfunction

  task automatic push(input logic [4:0] s, input int sz, input int lv, input int idx,
                      input logic st = 0, input logic ps = 0, input logic ap = 0,
                      input logic bo = 0, input logic bd = 0);
    item_t e;
    e.exp = ew(s, sz, lv, idx);
    e.st = st; e.ps = ps; e.ap = ap; e.bo = bo; e.bd = bd;
    sb.push_back(e);
  endtask

  task automatic push_render(input int sz, input int lv, input logic ps);
    for (int i = 0; i < sz; i++) begin
      push(S_RENDERIZA, sz, lv, i, 0, ps);
      push(S_ATUALIZA, sz, lv, i, 0, ps);
      push(S_PROXIMO, sz, lv, i, 0, ps);
    end
  endtask

  task automatic push_intro(input logic ps);
    push(S_IDLE, 3, 2, 0, 1);
    push(S_PREPARA, 3, 2, 0, 0, ps);
    push(S_GERA_INI, 3, 2, 0, 0, ps);
  endtask

  // Render pass, full ESPERA, then REGISTRA and MOVE; the COMPARA entry is pushed by the caller.
  task automatic push_loop(input int sz, input int lv);
    push_render(sz, lv, 0);
    for (int i = 0; i < TICK_CYCLES; i++) push(S_ESPERA, sz, lv, 0);
    push(S_REGISTRA, sz, lv, 0);
    push(S_MOVE, sz, lv, 0);
  endtask

  task automatic reset_dut();
    restart = 1; start = 0; pause = 0; is_at_apple = 0; is_at_border = 0; is_at_body = 0;
    repeat (2) @(negedge clock);
    restart = 0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    restart = 1; start = 0; pause = 0; is_at_apple = 0; is_at_border = 0; is_at_body = 0;
    #1;
    n_cmp++;
    if (obs !== ew(S_IDLE, 3, 2, 0)) begin
      n_bad++; $display("FAIL reset_async: got %h expected %h", obs, ew(S_IDLE, 3, 2, 0));
    end
    repeat (2) @(negedge clock);
    restart = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) push(S_IDLE, 3, 2, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL reset_idle t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_first_game();
    reset_dut();
    push_intro(0);
    push_loop(3, 2);
    push(S_COMPARA, 3, 2, 0);
    push(S_FEZ_NADA, 3, 2, 0);
    push(S_RENDERIZA, 3, 2, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL first_game t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_win();
    reset_dut();
    push_intro(0);
    push_loop(3, 2);
    push(S_COMPARA, 3, 2, 0, 0, 0, 1);
    push(S_COMEU, 3, 2, 0);
    push(S_CRESCE, 4, 2, 0);
    push(S_GERA_MACA, 4, 2, 0);
    push_loop(4, 2);
    push(S_COMPARA, 4, 2, 0, 0, 0, 1);
    push(S_COMEU, 4, 2, 0);
    push(S_CRESCE, 5, 2, 0);
    push(S_GANHOU, 5, 2, 0);
    push(S_GANHOU, 5, 2, 0, 1);
    push(S_PREPARA, 3, 2, 0);
    push(S_GERA_INI, 3, 2, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL win t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_lose();
    reset_dut();
    push_intro(0);
    push_loop(3, 2);
    push(S_COMPARA, 3, 2, 0, 0, 0, 0, 1);
    push(S_MORREU, 3, 2, 0);
    push(S_PREPARA, 3, 1, 0);
    push(S_GERA_INI, 3, 1, 0);
    push_loop(3, 1);
    push(S_COMPARA, 3, 1, 0, 0, 0, 0, 0, 1);
    push(S_PERDEU, 3, 1, 0);
    push(S_PERDEU, 3, 1, 0, 1);
    push(S_PREPARA, 3, 2, 0);
    push(S_GERA_INI, 3, 2, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL lose t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_apple_and_body();
    reset_dut();
    push_intro(0);
    push_loop(3, 2);
    push(S_COMPARA, 3, 2, 0, 0, 0, 1, 0, 1);
    push(S_MORREU, 3, 2, 0);
    push(S_PREPARA, 3, 1, 0);
    push(S_GERA_INI, 3, 1, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL apple_and_body t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_pause();
    reset_dut();
    push_intro(1);
    push_render(3, 2, 1);
    push(S_ESPERA, 3, 2, 0);
    push(S_ESPERA, 3, 2, 0, 0, 1);
    push(S_PAUSOU, 3, 2, 0, 0, 1);
    push(S_PAUSOU, 3, 2, 0);
    push(S_PAUSOU, 3, 2, 0, 1);
    for (int i = 0; i < TICK_CYCLES - 1; i++) push(S_ESPERA, 3, 2, 0);
    push(S_REGISTRA, 3, 2, 0);
    push(S_MOVE, 3, 2, 0);
    push(S_COMPARA, 3, 2, 0);
    push(S_FEZ_NADA, 3, 2, 0);
    push(S_RENDERIZA, 3, 2, 0);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL pause t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
  endtask

  task automatic test_restart_mid_render();
    reset_dut();
    push_intro(0);
    push(S_RENDERIZA, 3, 2, 0);
    push(S_ATUALIZA, 3, 2, 0);
    push(S_PROXIMO, 3, 2, 0);
    push(S_RENDERIZA, 3, 2, 1);
    while (sb.size() != 0) begin
      it = sb.pop_front();
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++; $display("FAIL restart_render t=%0t: got %h expected %h", $time, obs, it.exp);
      end
      start = it.st; pause = it.ps; is_at_apple = it.ap; is_at_border = it.bo; is_at_body = it.bd;
      @(negedge clock);
    end
    n_cmp++;
    if (obs !== ew(S_ATUALIZA, 3, 2, 1)) begin
      n_bad++; $display("FAIL restart_pre: got %h expected %h", obs, ew(S_ATUALIZA, 3, 2, 1));
    end
    restart = 1;
    #1;
    n_cmp++;
    if (obs !== ew(S_IDLE, 3, 2, 0)) begin
      n_bad++; $display("FAIL restart_async: got %h expected %h", obs, ew(S_IDLE, 3, 2, 0));
    end
    @(negedge clock);
    restart = 0;
    repeat (2) begin
      @(negedge clock);
      n_cmp++;
      if (obs !== ew(S_IDLE, 3, 2, 0)) begin
        n_bad++; $display("FAIL restart_release: got %h expected %h", obs, ew(S_IDLE, 3, 2, 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_game();
    test_win();
    test_lose();
    test_apple_and_body();
    test_pause();
    test_restart_mid_render();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
